// File: rtl/cheat_code_loader.sv
// cheat_code_loader: parses "AAAAAA:DDDD" text codes and programs them into the cheat table.
// Define CHEAT_ALIGN_CHK_EN to also reject odd addresses, which 68k word fetches never hit.
module cheat_code_loader (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] chr,
   input  logic       chr_valid,
   output logic       chr_ready,
   input  logic       clr_req,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       wr_req,
   input  logic       wr_ack,
   output logic       code_ok,
   output logic       err,
   output logic [1:0] err_code,
   output logic [4:0] slot_cnt,
   output logic       busy
);
   typedef enum logic [2:0] {COLLECT, FLUSH, CHECK, WRITE, CLEAR} state_t;
   state_t      state_q, state_d;
   logic [39:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d, idx_q, idx_d;
   logic [4:0]  slot_q, slot_d;
   logic [1:0]  ec_q, ec_d;
   logic        ok_q, ok_d;
   logic        take, is_dig, is_hex, is_skip, is_nl, bad_addr;
   logic [3:0]  nib;
   logic [7:0]  beat_byte;
   assign is_dig  = chr >= 8'h30 && chr <= 8'h39;
   assign is_hex  = is_dig || (chr >= 8'h41 && chr <= 8'h46) || (chr >= 8'h61 && chr <= 8'h66);
   assign nib     = is_dig ? chr[3:0] : chr[3:0] + 4'd9;
   assign is_skip = chr == 8'h3A || chr == 8'h2D || chr == 8'h20 || chr == 8'h0D;
   assign is_nl   = chr == 8'h0A;
`ifdef CHEAT_ALIGN_CHK_EN
   assign bad_addr = acc_q[39] || acc_q[16];
`else
   assign bad_addr = acc_q[39];
`endif
   assign chr_ready = rst_n && (state_q == COLLECT || state_q == FLUSH);
   assign take      = chr_valid && chr_ready;
   assign wr_req    = rst_n && (state_q == WRITE || state_q == CLEAR);
   assign busy      = rst_n && (state_q == CHECK || state_q == WRITE || state_q == CLEAR);
   assign beat_byte = idx_q == 4'd0 ? acc_q[39:32] : idx_q == 4'd1 ? acc_q[31:24] :
                      idx_q == 4'd2 ? acc_q[23:16] : idx_q == 4'd3 ? acc_q[15:8] : acc_q[7:0];
   assign wr_addr   = !rst_n ? 7'd0 : state_q == WRITE ? {slot_q[3:0], idx_q[2:0] + 3'd1} :
                      state_q == CLEAR ? {idx_q, 3'd1} : 7'd0;
   assign wr_data   = !rst_n ? 8'd0 : state_q == WRITE ? beat_byte : state_q == CLEAR ? 8'hFF : 8'd0;
   assign code_ok   = ok_q;
   assign err       = ec_q != 2'd0;
   assign err_code  = ec_q;
   assign slot_cnt  = slot_q;

   // Parse characters, validate finished codes and sequence the table write beats
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      slot_d  = slot_q;
      ec_d    = ec_q;
      ok_d    = 1'b0;
      case (state_q)
         COLLECT, FLUSH: begin
            if (clr_req) begin
               state_d = CLEAR;
               idx_d   = 4'd0;
               cnt_d   = 4'd0;
            end else if (take) begin
               if (state_q == FLUSH) begin
                  if (is_nl) state_d = COLLECT;
               end else if (is_hex) begin
                  if (cnt_q == 4'd10) begin
                     ec_d    = 2'd2;
                     cnt_d   = 4'd0;
                     state_d = FLUSH;
                  end else begin
                     acc_d = {acc_q[35:0], nib};
                     cnt_d = cnt_q + 4'd1;
                     if (cnt_q == 4'd0) ec_d = 2'd0;
                  end
               end else if (is_nl) begin
                  cnt_d = 4'd0;
                  if (cnt_q == 4'd10) state_d = CHECK;
                  else if (cnt_q != 4'd0) ec_d = 2'd2;
               end else if (!is_skip) begin
                  ec_d    = 2'd1;
                  cnt_d   = 4'd0;
                  state_d = FLUSH;
               end
            end
         end
         CHECK: begin
            if (slot_q[4] || bad_addr) begin
               ec_d    = 2'd3;
               state_d = COLLECT;
            end else begin
               idx_d   = 4'd0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (wr_ack) begin
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd4) begin
                  slot_d  = slot_q + 5'd1;
                  ok_d    = 1'b1;
                  state_d = COLLECT;
               end
            end
         end
         CLEAR: begin
            if (wr_ack) begin
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd15) begin
                  slot_d  = 5'd0;
                  ec_d    = 2'd0;
                  state_d = COLLECT;
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // State registers with synchronous active-low reset; table contents are left alone
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= COLLECT;
         acc_q   <= 40'd0;
         cnt_q   <= 4'd0;
         idx_q   <= 4'd0;
         slot_q  <= 5'd0;
         ec_q    <= 2'd0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         slot_q  <= slot_d;
         ec_q    <= ec_d;
         ok_q    <= ok_d;
      end
   end
endmodule

// File: tb/tb_cheat_code_loader.sv
// tb_cheat_code_loader: directed table-driven bench for cheat_code_loader.
module tb_cheat_code_loader;
   typedef struct {
      string       s;
      int          e;
      bit          w;
      logic [39:0] val;
   } vec_t;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic [7:0] chr = 8'd0;
   logic       chr_valid = 1'b0, clr_req = 1'b0, wr_ack = 1'b1;
   logic       chr_ready, wr_req, code_ok, err, busy;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   logic [1:0] err_code;
   logic [4:0] slot_cnt;

   int          n_chk = 0, n_err = 0, ok_cnt = 0, req_cyc = 0, slot = 0;
   logic [14:0] log_q[$];
   vec_t        tbl[10];

   cheat_code_loader dut (
      .clk(clk), .rst_n(rst_n), .chr(chr), .chr_valid(chr_valid), .chr_ready(chr_ready),
      .clr_req(clr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_req(wr_req), .wr_ack(wr_ack),
      .code_ok(code_ok), .err(err), .err_code(err_code), .slot_cnt(slot_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   // Record accepted write beats, request cycles and completion pulses
   always @(negedge clk) begin
      if (wr_req && wr_ack) log_q.push_back({wr_addr, wr_data});
      if (wr_req) req_cyc++;
      if (code_ok) ok_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic put(input logic [7:0] c);
      int n = 0;
      chr = c;
      chr_valid = 1'b1;
      while (!chr_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_chk++;
         n_err++;
         $display("FAIL put_timeout: chr_ready stayed 0, expected 1");
      end
      @(posedge clk);
      #1;
      chr_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) put(s[i]);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_chk++;
         n_err++;
         $display("FAIL idle_timeout: busy stayed 1, expected 0");
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int base;
      tbl[0] = '{"12G456:0000\n",        1, 1'b0, 40'h0};
      tbl[1] = '{"01F2A4:4E71\n",        0, 1'b1, 40'h01F2A44E71};
      tbl[2] = '{"12345:0000\n",         2, 1'b0, 40'h0};
      tbl[3] = '{"\n",                   2, 1'b0, 40'h0};
      tbl[4] = '{"800000:0000\n",        3, 1'b0, 40'h0};
      tbl[5] = '{"0a0b0c-d0e0\015\n",    0, 1'b1, 40'h0A0B0CD0E0};
      tbl[6] = '{"123456:78901\n",       2, 1'b0, 40'h0};
      tbl[7] = '{"7FFFFE 55AA\n",        0, 1'b1, 40'h7FFFFE55AA};
`ifdef CHEAT_ALIGN_CHK_EN
      tbl[8] = '{"000101:1234\n",        3, 1'b0, 40'h0001011234};
`else
      tbl[8] = '{"000101:1234\n",        0, 1'b1, 40'h0001011234};
`endif
      tbl[9] = '{"1234567890\n",         0, 1'b1, 40'h1234567890};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_chr_ready", int'(chr_ready), 0);
      chk("rst_wr_req", int'(wr_req), 0);
      chk("rst_code_ok", int'(code_ok), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_err_code", int'(err_code), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_wr_data", int'(wr_data), 0);
      chk("rst_slot_cnt", int'(slot_cnt), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_ready", int'(chr_ready), 1);

      for (int r = 0; r < 10; r++) begin
         log_q.delete();
         ok_cnt = 0;
         req_cyc = 0;
         send_str(tbl[r].s);
         wait_idle();
         chk($sformatf("row%0d_err_code", r), int'(err_code), tbl[r].e);
         chk($sformatf("row%0d_err", r), int'(err), int'(tbl[r].e != 0));
         chk($sformatf("row%0d_writes", r), log_q.size(), tbl[r].w ? 5 : 0);
         chk($sformatf("row%0d_req_cycles", r), req_cyc, tbl[r].w ? 5 : 0);
         chk($sformatf("row%0d_code_ok", r), ok_cnt, tbl[r].w ? 1 : 0);
         if (tbl[r].w && log_q.size() == 5)
            for (int k = 0; k < 5; k++) begin
               chk($sformatf("row%0d_addr%0d", r, k), int'(log_q[k][14:8]), slot * 8 + k + 1);
               chk($sformatf("row%0d_data%0d", r, k), int'(log_q[k][7:0]), int'(tbl[r].val[39 - 8 * k -: 8]));
            end
         if (tbl[r].w) slot++;
         chk($sformatf("row%0d_slot_cnt", r), int'(slot_cnt), slot);
      end

      log_q.delete();
      base = slot;
      while (slot < 16) begin
         send_str("000200:0000\n");
         wait_idle();
         slot++;
      end
      chk("fill_writes", log_q.size(), 5 * (16 - base));
      chk("fill_slot_cnt", int'(slot_cnt), 16);

      log_q.delete();
      send_str("000100:1234\n");
      wait_idle();
      chk("full_writes", log_q.size(), 0);
      chk("full_err_code", int'(err_code), 3);
      chk("full_slot_cnt", int'(slot_cnt), 16);

      log_q.delete();
      req_cyc = 0;
      @(posedge clk);
      #1 clr_req = 1'b1;
      @(posedge clk);
      #1 clr_req = 1'b0;
      wait_idle();
      chk("clr_writes", log_q.size(), 16);
      chk("clr_req_cycles", req_cyc, 16);
      if (log_q.size() == 16)
         for (int i = 0; i < 16; i++) begin
            chk($sformatf("clr_addr%0d", i), int'(log_q[i][14:8]), i * 8 + 1);
            chk($sformatf("clr_data%0d", i), int'(log_q[i][7:0]), 8'hFF);
         end
      chk("clr_slot_cnt", int'(slot_cnt), 0);
      chk("clr_err", int'(err), 0);
      slot = 0;

      send_str("12");
      chr = 8'h33;
      chr_valid = 1'b1;
      clr_req = 1'b1;
      @(posedge clk);
      #1;
      chr_valid = 1'b0;
      clr_req = 1'b0;
      wait_idle();
      log_q.delete();
      send_str("000010:2222\n");
      wait_idle();
      chk("abort_writes", log_q.size(), 5);
      chk("abort_err_code", int'(err_code), 0);
      if (log_q.size() == 5) begin
         chk("abort_first", int'(log_q[0]), {7'd1, 8'h00});
         chk("abort_last", int'(log_q[4]), {7'd5, 8'h22});
      end
      slot = 1;
      chk("abort_slot_cnt", int'(slot_cnt), slot);

      send_str("11FFEE:CCDD\n");
      @(negedge clk);
      chk("lat_check_req", int'(wr_req), 0);
      chk("lat_check_busy", int'(busy), 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("lat_beat0_req", int'(wr_req), 1);
      chk("lat_beat0_addr", int'(wr_addr), slot * 8 + 1);
      chk("lat_beat0_data", int'(wr_data), 8'h11);
      @(posedge clk);
      #1 wr_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_req", i), int'(wr_req), 1);
         chk($sformatf("stall%0d_addr", i), int'(wr_addr), slot * 8 + 2);
         chk($sformatf("stall%0d_data", i), int'(wr_data), 8'hFF);
         @(posedge clk);
         #1;
         if (i == 2) wr_ack = 1'b1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", int'(chr_ready), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_rst_req", int'(wr_req), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_slot_cnt", int'(slot_cnt), 0);
      chk("mid_rst_code_ok", int'(code_ok), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_release_ready", int'(chr_ready), 1);
      chk("mid_rst_release_req", int'(wr_req), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
